rptr_empty_lvl: RTL

- Read-side pointer and status block for the async FIFO, living entirely in the read clock domain.
- Contains a parametrised multi-flop synchroniser for the incoming Gray write pointer, plus Gray-to-binary conversion.
- Drives the binary read address and a registered Gray read pointer back to the write domain.
- Generates registered empty, almost_empty, fill level and a sticky underflow flag.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_bus.sv | 26 ++
 rtl/rptr_empty_lvl.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer helpers and constants for the async FIFO pointer blocks
package fifo_pkg;

    localparam int SYNC_MIN = 2;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_bus.sv
// sync_bus: STAGES-deep flop chain carrying a Gray bus across a clock boundary
module sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    // plain shift chain, no logic between stages
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '{default: '0};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-side pointer, empty/level status and sticky underflow for an async FIFO
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic                  clr_uflow,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  underflow
);

    localparam int PW     = ptr_w(ADDR_WIDTH);
    localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0] w_wq_gray;
    logic [PW-1:0] w_wq_bin;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_level_next;
    logic          w_do_read;
    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic          r_empty;
    logic          r_ae;
    logic          r_uflow;

    sync_bus #(
        .WIDTH (PW),
        .STAGES(STAGES)
    ) u_sync (
        .i_clk(rclk),
        .i_rst(rrst),
        .i_d  (wptr_gray),
        .o_q  (w_wq_gray)
    );

    assign w_wq_bin     = PW'(gray2bin(32'(w_wq_gray)));
    assign w_do_read    = rinc & ~r_empty;
    assign w_rbin_next  = r_rbin + PW'(w_do_read);
    assign w_rgray_next = PW'(bin2gray(32'(w_rbin_next)));
    assign w_level_next = w_wq_bin - w_rbin_next;

    // advance the binary and Gray read pointers together on an honoured read
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rbin <= '0;
            r_rptr <= '0;
        end else begin
            r_rbin <= w_rbin_next;
            r_rptr <= w_rgray_next;
        end
    end

    // status is computed from next-state pointers so a draining read flags empty on the same edge
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_empty <= 1'b1;
            r_ae    <= 1'b1;
            r_level <= '0;
        end else begin
            r_empty <= (w_rgray_next == w_wq_gray);
            r_ae    <= (w_level_next <= AE_LVL);
            r_level <= w_level_next;
        end
    end

    // sticky underflow; a new violation outranks a simultaneous clear
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) r_uflow <= 1'b0;
        else      r_uflow <= (rinc & r_empty) | (r_uflow & ~clr_uflow);
    end

    assign raddr        = r_rbin[ADDR_WIDTH-1:0];
    assign rptr         = r_rptr;
    assign empty        = r_empty;
    assign almost_empty = r_ae;
    assign rlevel       = r_level;
    assign underflow    = r_uflow;

endmodule
